alu_rs: RTL

Reservation station for the integer ALU in the out-of-order core. It sits between dispatch and the ALU. It buffers decoded ALU instructions until both operands are available, snoops the two common data buses (ALU result and load/store result) to capture pending operands, and issues at most one ready instruction per cycle to the ALU. The ALU inputs are driven from registers.

---
 rtl/alu_rs_if.sv | 52 +++++
 rtl/alu_rs.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/alu_rs_if.sv
// alu_rs_if: dispatch/CDB inputs and ALU issue outputs of the ALU station.
// master drives dispatch and CDB; slave is the station.
interface alu_rs_if #(
  parameter int DATA_W = 32,
  parameter int TAG_W  = 4,
  parameter int NAME_W = 5,
  parameter int OP_W   = 6,
  parameter int ADDR_W = 32
);
  logic              clear;
  logic              inEn;
  logic [OP_W-1:0]   inOp;
  logic [DATA_W-1:0] inOprO;
  logic [DATA_W-1:0] inOprT;
  logic [TAG_W-1:0]  inTagO;
  logic [TAG_W-1:0]  inTagT;
  logic [TAG_W-1:0]  inWrtTag;
  logic [NAME_W-1:0] inWrtName;
  logic [ADDR_W-1:0] inAddr;
  logic              aluCdbEn;
  logic [TAG_W-1:0]  aluCdbTag;
  logic [DATA_W-1:0] aluCdbData;
  logic              lsCdbEn;
  logic [TAG_W-1:0]  lsCdbTag;
  logic [DATA_W-1:0] lsCdbData;
  logic              rsFull;
  logic              ALUworkEn;
  logic [DATA_W-1:0] operandO;
  logic [DATA_W-1:0] operandT;
  logic [TAG_W-1:0]  wrtTag;
  logic [NAME_W-1:0] wrtName;
  logic [OP_W-1:0]   opCode;
  logic [ADDR_W-1:0] instAddr;

  modport master (
    output clear, inEn, inOp, inOprO, inOprT, inTagO, inTagT,
    output inWrtTag, inWrtName, inAddr,
    output aluCdbEn, aluCdbTag, aluCdbData,
    output lsCdbEn, lsCdbTag, lsCdbData,
    input  rsFull, ALUworkEn, operandO, operandT,
    input  wrtTag, wrtName, opCode, instAddr
  );

  modport slave (
    input  clear, inEn, inOp, inOprO, inOprT, inTagO, inTagT,
    input  inWrtTag, inWrtName, inAddr,
    input  aluCdbEn, aluCdbTag, aluCdbData,
    input  lsCdbEn, lsCdbTag, lsCdbData,
    output rsFull, ALUworkEn, operandO, operandT,
    output wrtTag, wrtName, opCode, instAddr
  );
endinterface

// File: rtl/alu_rs.sv
// alu_rs: ALU reservation station, dual-CDB snoop, one registered issue/cycle.
// ALU_RS_AGE_EN selects oldest-ready issue instead of lowest ready index.
module alu_rs #(
  parameter int ENTRIES = 8,
  parameter int DATA_W  = 32,
  parameter int TAG_W   = 4,
  parameter int NAME_W  = 5,
  parameter int OP_W    = 6,
  parameter int ADDR_W  = 32,
  parameter logic [TAG_W-1:0] TAG_FREE = {TAG_W{1'b1}}
) (
  input logic     clk,
  input logic     rst,
  alu_rs_if.slave bus
);
  localparam int IDX_W = $clog2(ENTRIES);

  typedef struct packed {
    logic [OP_W-1:0]   op;
    logic [TAG_W-1:0]  tagO;
    logic [DATA_W-1:0] datO;
    logic [TAG_W-1:0]  tagT;
    logic [DATA_W-1:0] datT;
    logic [TAG_W-1:0]  wtag;
    logic [NAME_W-1:0] wname;
    logic [ADDR_W-1:0] addr;
  } slot_t;

  typedef logic [TAG_W+DATA_W-1:0] opnd_t;

  logic [ENTRIES-1:0] valid_q, valid_d, ready;
  slot_t              slot_q [ENTRIES];
  slot_t              slot_d [ENTRIES];
  logic               iss_en, free_en, accept;
  logic [IDX_W-1:0]   iss_idx, free_idx;

  logic              en_q;
  logic [DATA_W-1:0] oprO_q, oprT_q;
  logic [TAG_W-1:0]  wtag_q;
  logic [NAME_W-1:0] wname_q;
  logic [OP_W-1:0]   op_q;
  logic [ADDR_W-1:0] addr_q;

`ifdef ALU_RS_AGE_EN
  logic [IDX_W-1:0] age_q [ENTRIES];
  logic [IDX_W-1:0] age_d [ENTRIES];
  logic [IDX_W-1:0] best_age;
`endif

  // ALU CDB has priority when both buses carry the same tag.
  function automatic opnd_t snoop(input logic [TAG_W-1:0]  tag,
                                  input logic [DATA_W-1:0] dat);
    opnd_t r;
    r = {tag, dat};
    if (tag != TAG_FREE) begin
      if (bus.aluCdbEn && tag == bus.aluCdbTag)
        r = {TAG_FREE, bus.aluCdbData};
      else if (bus.lsCdbEn && tag == bus.lsCdbTag)
        r = {TAG_FREE, bus.lsCdbData};
    end
    return r;
  endfunction

  always_comb begin
    for (int i = 0; i < ENTRIES; i++)
      ready[i] = valid_q[i] &&
                 slot_q[i].tagO == TAG_FREE &&
                 slot_q[i].tagT == TAG_FREE;
  end

  always_comb begin
    iss_en  = 1'b0;
    iss_idx = '0;
`ifdef ALU_RS_AGE_EN
    best_age = '0;
    for (int i = 0; i < ENTRIES; i++)
      if (ready[i] && (!iss_en || age_q[i] > best_age)) begin
        iss_en   = 1'b1;
        iss_idx  = IDX_W'(i);
        best_age = age_q[i];
      end
`else
    for (int i = 0; i < ENTRIES; i++)
      if (ready[i] && !iss_en) begin
        iss_en  = 1'b1;
        iss_idx = IDX_W'(i);
      end
`endif
  end

  always_comb begin
    free_en  = 1'b0;
    free_idx = '0;
    for (int i = 0; i < ENTRIES; i++)
      if (!valid_q[i] && !free_en) begin
        free_en  = 1'b1;
        free_idx = IDX_W'(i);
      end
  end

  assign bus.rsFull = &valid_q;
  assign accept     = bus.inEn && free_en;

  always_comb begin
    valid_d = valid_q;
    slot_d  = slot_q;
`ifdef ALU_RS_AGE_EN
    age_d = age_q;
`endif
    for (int i = 0; i < ENTRIES; i++)
      if (valid_q[i]) begin
        {slot_d[i].tagO, slot_d[i].datO} =
          snoop(slot_q[i].tagO, slot_q[i].datO);
        {slot_d[i].tagT, slot_d[i].datT} =
          snoop(slot_q[i].tagT, slot_q[i].datT);
      end
    if (iss_en)
      valid_d[iss_idx] = 1'b0;
`ifdef ALU_RS_AGE_EN
    for (int i = 0; i < ENTRIES; i++)
      if (valid_q[i] && valid_d[i] && age_q[i] != '1)
        age_d[i] = age_q[i] + 1'b1;
`endif
    if (accept) begin
      valid_d[free_idx]       = 1'b1;
      slot_d[free_idx].op     = bus.inOp;
      slot_d[free_idx].wtag   = bus.inWrtTag;
      slot_d[free_idx].wname  = bus.inWrtName;
      slot_d[free_idx].addr   = bus.inAddr;
      {slot_d[free_idx].tagO, slot_d[free_idx].datO} =
        snoop(bus.inTagO, bus.inOprO);
      {slot_d[free_idx].tagT, slot_d[free_idx].datT} =
        snoop(bus.inTagT, bus.inOprT);
`ifdef ALU_RS_AGE_EN
      age_d[free_idx] = '0;
`endif
    end
    if (bus.clear)
      valid_d = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        slot_q[i] <= '0;
`ifdef ALU_RS_AGE_EN
        age_q[i] <= '0;
`endif
      end
    end else begin
      valid_q <= valid_d;
      slot_q  <= slot_d;
`ifdef ALU_RS_AGE_EN
      age_q <= age_d;
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en_q    <= 1'b0;
      oprO_q  <= '0;
      oprT_q  <= '0;
      wtag_q  <= TAG_FREE;
      wname_q <= '0;
      op_q    <= '0;
      addr_q  <= '0;
    end else if (bus.clear) begin
      en_q    <= 1'b0;
      oprO_q  <= '0;
      oprT_q  <= '0;
      wtag_q  <= TAG_FREE;
      wname_q <= '0;
      op_q    <= '0;
      addr_q  <= '0;
    end else begin
      en_q <= iss_en;
      if (iss_en) begin
        oprO_q  <= slot_q[iss_idx].datO;
        oprT_q  <= slot_q[iss_idx].datT;
        wtag_q  <= slot_q[iss_idx].wtag;
        wname_q <= slot_q[iss_idx].wname;
        op_q    <= slot_q[iss_idx].op;
        addr_q  <= slot_q[iss_idx].addr;
      end
    end
  end

  assign bus.ALUworkEn = en_q;
  assign bus.operandO  = oprO_q;
  assign bus.operandT  = oprT_q;
  assign bus.wrtTag    = wtag_q;
  assign bus.wrtName   = wname_q;
  assign bus.opCode    = op_q;
  assign bus.instAddr  = addr_q;
endmodule
